// File: rtl/peripheral_wb_pkg.sv
// Shared Wishbone B3 encodings for the RAM slave front-end.
//   CTI_* : cycle type identifiers (wb_cti_i)
//   BTE_* : burst type extensions (wb_bte_i)
//   cti_reserved() flags cycle types this slave answers with an error.
package peripheral_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    function automatic logic cti_reserved(input logic [2:0] cti);
        return (cti == 3'b011) || (cti == 3'b100) || (cti == 3'b101) || (cti == 3'b110);
    endfunction

endpackage

// File: rtl/peripheral_ram_wb_burst_adr.sv
// Next word index of an incrementing Wishbone burst.
//   idx      : current word index
//   bte      : burst type (linear / wrap4 / wrap8 / wrap16)
//   next_idx : index of the following beat
// Linear wraps modulo 2**AW; wrapN only advances the low log2(N) bits.
module peripheral_ram_wb_burst_adr
    import peripheral_wb_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [AW-1:0] idx,
    input  logic [1:0]    bte,
    output logic [AW-1:0] next_idx
);

    logic [AW-1:0] mask;
    logic [AW-1:0] inc;

    always_comb begin
        mask = '1;
        case (bte)
            BTE_WRAP4:  mask = AW'(4'h3);
            BTE_WRAP8:  mask = AW'(4'h7);
            BTE_WRAP16: mask = AW'(4'hF);
            default:    mask = '1;
        endcase
        inc      = idx + AW'(1);
        // bits outside the wrap window stay put, bits inside take the increment
        next_idx = (idx & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/peripheral_ram_wb_slave.sv
// Wishbone B3 slave front-end for a single-port RAM with registered read.
//   wb_*      : Wishbone slave port (classic + incrementing bursts)
//   ram_we    : byte write enables, only in the acknowledged cycle
//   ram_din   : write data (wb_dat_i pass-through)
//   ram_waddr : write word index from wb_adr_i
//   ram_raddr : read word index; next burst beat once a burst is streaming
//   ram_dout  : registered RAM read data, forwarded on wb_dat_o
module peripheral_ram_wb_slave
    import peripheral_wb_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 32
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic [31:0]   wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    ram_we,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_dout
);

    logic          valid;
    logic          last;
    logic          bad;
    logic [AW-1:0] idx;
    logic [AW-1:0] next_idx;
    logic          unused_adr;

    assign valid      = wb_cyc_i & wb_stb_i;
    assign last       = (wb_cti_i != CTI_INCR);
    assign bad        = cti_reserved(wb_cti_i);
    assign idx        = wb_adr_i[AW+1:2];
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

    peripheral_ram_wb_burst_adr #(.AW(AW)) u_burst_adr (
        .idx      (idx),
        .bte      (wb_bte_i),
        .next_idx (next_idx)
    );

    // A terminating beat (anything but INCR) that is already acked must not
    // be acked again; this yields the two-cycle classic cadence and drops
    // ack right after the end-of-burst beat.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            wb_ack_o <= valid & ~bad & ~((wb_ack_o | wb_err_o) & last);
            wb_err_o <= valid & bad & ~wb_err_o;
        end
    end

    // Write lands in the ack cycle while the master still holds adr/dat, so
    // an async reset that clears ack also suppresses the pending write.
    assign ram_we    = wb_sel_i & {4{valid & wb_we_i & wb_ack_o}};
    assign ram_din   = wb_dat_i;
    assign ram_waddr = idx;

    // While a burst streams, the beat on the bus is already being acked, so
    // fetch the following beat to have its data ready on the next ack.
    assign ram_raddr = (wb_ack_o && wb_cti_i == CTI_INCR) ? next_idx : idx;
    assign wb_dat_o  = ram_dout;

endmodule

// File: tb/tb_peripheral_ram_wb_slave.sv
module tb_peripheral_ram_wb_slave;
    import peripheral_wb_pkg::*;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [7:0]  widx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          preload = 1'b1;
    logic [31:0]   adr = '0;
    logic [31:0]   dat = '0;
    logic [3:0]    sel = '0;
    logic          we = 1'b0;
    logic [2:0]    cti = '0;
    logic [1:0]    bte = '0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          ack;
    logic          err;
    logic [31:0]   dat_o;
    logic [3:0]    ram_we;
    logic [31:0]   ram_din;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_dout;

    logic [31:0]   mem [DEPTH];
    exp_t          q[$];
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    peripheral_ram_wb_slave #(.DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cti_i  (cti),
        .wb_bte_i  (bte),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_ack_o  (ack),
        .wb_err_o  (err),
        .wb_dat_o  (dat_o),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_waddr (ram_waddr),
        .ram_raddr (ram_raddr),
        .ram_dout  (ram_dout)
    );

    // RAM environment: byte writes, registered read, preload mem[i] = i
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= i;
        end else begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_waddr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
        ram_dout <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every ack/err consumes one scoreboard entry
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && !preload) begin
            if (ack || err) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", ack, err);
                end else begin
                    e = q.pop_front();
                    case (e.kind)
                        K_RD: begin
                            check("rd_err", {31'd0, err}, 32'd0);
                            check("rd_data", dat_o, e.data);
                        end
                        K_WR: begin
                            check("wr_err", {31'd0, err}, 32'd0);
                            check("wr_we", {28'd0, ram_we}, {28'd0, e.sel});
                            check("wr_waddr", {24'd0, ram_waddr}, {24'd0, e.widx});
                            check("wr_din", ram_din, e.data);
                        end
                        default: begin
                            check("err_ack", {31'd0, ack}, 32'd0);
                            check("err_we", {28'd0, ram_we}, 32'd0);
                        end
                    endcase
                end
            end else begin
                check("we_no_ack", {28'd0, ram_we}, 32'd0);
            end
        end
    end

    task automatic drive_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
        sel = 4'h0; adr = '0; dat = '0;
    endtask

    task automatic wait_resp(output int w);
        w = 0;
        forever begin
            @(negedge clk);
            if (ack || err) return;
            w++;
            if (w > 20) begin
                total++; bad++;
                $display("FAIL resp_timeout: got no ack/err expected one within 20 cycles");
                return;
            end
        end
    endtask

    task automatic classic(input logic we_, input logic [2:0] cti_, input logic [7:0] widx,
                           input logic [31:0] d, input logic [3:0] s, input int kind,
                           input logic [31:0] expd);
        int   w;
        exp_t e;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = we_; cti = cti_; bte = BTE_LINEAR;
        sel = s; dat = d; adr = {22'd0, widx, 2'b00};
        e.kind = kind; e.data = (kind == K_RD) ? expd : d; e.sel = s; e.widx = widx;
        q.push_back(e);
        wait_resp(w);
        check("classic_lat", w, 1);
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic rd_burst(input int n, input logic [7:0] ix [8], input logic [1:0] b);
        int   w;
        exp_t e;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = b;
            cti = (k == n-1) ? CTI_EOB : CTI_INCR;
            adr = {22'd0, ix[k], 2'b00};
            e.kind = K_RD; e.data = {24'd0, ix[k]}; e.sel = 4'h0; e.widx = ix[k];
            q.push_back(e);
            wait_resp(w);
            check($sformatf("burst_lat%0d", k), w, (k == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        check("eob_ack_drop", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        logic [7:0] ix [8];
        int         w;
        exp_t       e;

        // reset with a live write request on the bus: nothing may fire
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h10; dat = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_we", {28'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        drive_idle();
        preload = 1'b0;
        rst_n = 1'b1;

        ix = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        rd_burst(8, ix, BTE_LINEAR);
        ix = '{8'd2, 8'd3, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        rd_burst(4, ix, BTE_WRAP4);
        ix = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        rd_burst(2, ix, BTE_LINEAR);

        classic(1'b1, CTI_CLASSIC, 8'd4, 32'hDEADBEEF, 4'hF, K_WR, 32'h0);
        classic(1'b0, CTI_CLASSIC, 8'd4, 32'h0, 4'hF, K_RD, 32'hDEADBEEF);
        classic(1'b1, CTI_CLASSIC, 8'd5, 32'h11223344, 4'hF, K_WR, 32'h0);
        classic(1'b1, CTI_CONST, 8'd5, 32'h0000AA00, 4'b0010, K_WR, 32'h0);
        classic(1'b0, CTI_CLASSIC, 8'd5, 32'h0, 4'hF, K_RD, 32'h1122AA44);

        // reserved cycle type: error, no write
        classic(1'b1, 3'b011, 8'd4, 32'hBADBAD00, 4'hF, K_ERR, 32'h0);
        classic(1'b0, CTI_CLASSIC, 8'd4, 32'h0, 4'hF, K_RD, 32'hDEADBEEF);

        // write burst to 0x20.., reset right after the third beat commits
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; bte = BTE_LINEAR; cti = CTI_INCR;
            adr = {22'd0, 8'h20 + 8'(k), 2'b00};
            dat = 32'hA0 + k;
            e.kind = K_WR; e.data = 32'hA0 + k; e.sel = 4'hF; e.widx = 8'h20 + 8'(k);
            q.push_back(e);
            wait_resp(w);
            check($sformatf("wburst_lat%0d", k), w, (k == 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        adr = {22'd0, 8'h23, 2'b00};
        dat = 32'hA3;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ack", {31'd0, ack}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        check("abort_we", {28'd0, ram_we}, 32'd0);
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b1;

        classic(1'b0, CTI_CLASSIC, 8'h22, 32'h0, 4'hF, K_RD, 32'h000000A2);
        classic(1'b0, CTI_CLASSIC, 8'h23, 32'h0, 4'hF, K_RD, 32'h00000023);
        classic(1'b0, CTI_CLASSIC, 8'h24, 32'h0, 4'hF, K_RD, 32'h00000024);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
